// File: rtl/dice_special_reg_seq.sv
// Special-register sequencer: walks a CTA's (x,y,z) thread space and streams
// per-thread special register values (tid, ntid, ctaid, nctaid, linear id, consts).
module dice_special_reg_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned NUM_CONST  = 4,
  parameter int unsigned MAX_NTID   = 512,
  parameter int unsigned CTA_WIDTH  = 16,
  localparam int unsigned TID_WIDTH  = $clog2(MAX_NTID),
  localparam int unsigned DIM_WIDTH  = TID_WIDTH + 1,
  localparam int unsigned CIDX_WIDTH = (NUM_CONST > 1) ? $clog2(NUM_CONST) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            cfg_we,
  input  logic [CIDX_WIDTH-1:0]           cfg_idx,
  input  logic [DATA_WIDTH-1:0]           cfg_data,
  input  logic                            launch_valid,
  output logic                            launch_ready,
  input  logic [DIM_WIDTH-1:0]            ntid_x,
  input  logic [DIM_WIDTH-1:0]            ntid_y,
  input  logic [DIM_WIDTH-1:0]            ntid_z,
  input  logic [CTA_WIDTH-1:0]            ctaid_x,
  input  logic [CTA_WIDTH-1:0]            ctaid_y,
  input  logic [CTA_WIDTH-1:0]            ctaid_z,
  input  logic [CTA_WIDTH-1:0]            nctaid_x,
  input  logic [CTA_WIDTH-1:0]            nctaid_y,
  input  logic [CTA_WIDTH-1:0]            nctaid_z,
  input  logic [NUM_PORTS*5-1:0]          port_sel,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
  output logic                            busy
);

  localparam int unsigned SEL_WIDTH = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                          state_q, state_d;
  logic [2:0][TID_WIDTH-1:0]       tid_q, tid_d;
  logic [DATA_WIDTH-1:0]           lin_q, lin_d;
  logic [2:0][DIM_WIDTH-1:0]       ntid_q, ntid_d;
  logic [2:0][CTA_WIDTH-1:0]       ctaid_q, ctaid_d;
  logic [2:0][CTA_WIDTH-1:0]       nctaid_q, nctaid_d;
  logic [NUM_PORTS*SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [DATA_WIDTH-1:0]           const_q [NUM_CONST];
  logic [DATA_WIDTH-1:0]           const_d [NUM_CONST];
  logic                            out_valid_q, out_valid_d;
  logic                            out_last_q, out_last_d;
  logic                            launch_ready_q, launch_ready_d;
  logic                            busy_q, busy_d;
  logic [NUM_PORTS*DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                            fire;
  logic                            launch;
  logic                            dims_ok;
  logic [SEL_WIDTH-1:0]            psel;
  logic [DATA_WIDTH-1:0]           pval;

  // True when a thread index sits on the last value of its dimension.
  function automatic logic at_end(input logic [TID_WIDTH-1:0] t,
                                  input logic [DIM_WIDTH-1:0] n);
    return DIM_WIDTH'(t) == (n - DIM_WIDTH'(1));
  endfunction

  // Next-state: constant writes, abort, launch and thread-index walk.
  always_comb begin
    state_d  = state_q;
    tid_d    = tid_q;
    lin_d    = lin_q;
    ntid_d   = ntid_q;
    ctaid_d  = ctaid_q;
    nctaid_d = nctaid_q;
    sel_d    = sel_q;
    const_d  = const_q;
    fire     = out_valid_q & out_ready;
    launch   = launch_valid & launch_ready_q;
    dims_ok  = (ntid_x != '0) && (ntid_y != '0) && (ntid_z != '0);

    for (int k = 0; k < NUM_CONST; k++) begin
      if (cfg_we && (cfg_idx == CIDX_WIDTH'(k))) begin
        const_d[k] = cfg_data;
      end
    end

    if (clr) begin
      state_d = IDLE;
      tid_d   = '0;
      lin_d   = '0;
    end else if (launch) begin
      ntid_d   = {ntid_z, ntid_y, ntid_x};
      ctaid_d  = {ctaid_z, ctaid_y, ctaid_x};
      nctaid_d = {nctaid_z, nctaid_y, nctaid_x};
      sel_d    = port_sel;
      tid_d    = '0;
      lin_d    = '0;
      // A zero-sized dimension means an empty CTA: never leave IDLE.
      state_d  = dims_ok ? RUN : IDLE;
    end else if (fire) begin
      if (out_last_q) begin
        state_d = IDLE;
      end else begin
        lin_d = lin_q + DATA_WIDTH'(1);
        if (at_end(tid_q[0], ntid_q[0])) begin
          tid_d[0] = '0;
          if (at_end(tid_q[1], ntid_q[1])) begin
            tid_d[1] = '0;
            tid_d[2] = tid_q[2] + TID_WIDTH'(1);
          end else begin
            tid_d[1] = tid_q[1] + TID_WIDTH'(1);
          end
        end else begin
          tid_d[0] = tid_q[0] + TID_WIDTH'(1);
        end
      end
    end
  end

  // Output words are built from next-state values so they register with it.
  always_comb begin
    out_valid_d    = (state_d == RUN);
    busy_d         = (state_d != IDLE);
    launch_ready_d = (state_d == IDLE);
    out_last_d     = out_valid_d & at_end(tid_d[0], ntid_d[0]) &
                     at_end(tid_d[1], ntid_d[1]) & at_end(tid_d[2], ntid_d[2]);
    out_data_d     = '0;
    psel           = '0;
    pval           = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      psel = sel_d[p*SEL_WIDTH +: SEL_WIDTH];
      pval = '0;
      case (psel)
        5'd0:  pval = DATA_WIDTH'(tid_d[0]);
        5'd1:  pval = DATA_WIDTH'(tid_d[1]);
        5'd2:  pval = DATA_WIDTH'(tid_d[2]);
        5'd3:  pval = DATA_WIDTH'(ntid_d[0]);
        5'd4:  pval = DATA_WIDTH'(ntid_d[1]);
        5'd5:  pval = DATA_WIDTH'(ntid_d[2]);
        5'd6:  pval = DATA_WIDTH'(ctaid_d[0]);
        5'd7:  pval = DATA_WIDTH'(ctaid_d[1]);
        5'd8:  pval = DATA_WIDTH'(ctaid_d[2]);
        5'd9:  pval = DATA_WIDTH'(nctaid_d[0]);
        5'd10: pval = DATA_WIDTH'(nctaid_d[1]);
        5'd11: pval = DATA_WIDTH'(nctaid_d[2]);
        5'd12: pval = lin_d;
        default: begin
          for (int k = 0; k < NUM_CONST; k++) begin
            if (psel == SEL_WIDTH'(16 + k)) begin
              pval = const_d[k];
            end
          end
        end
      endcase
      out_data_d[p*DATA_WIDTH +: DATA_WIDTH] = pval;
    end
  end

  // State and output registers; reset dominates every other control.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      tid_q          <= '0;
      lin_q          <= '0;
      ntid_q         <= '0;
      ctaid_q        <= '0;
      nctaid_q       <= '0;
      sel_q          <= '0;
      const_q        <= '{default: '0};
      out_valid_q    <= 1'b0;
      out_last_q     <= 1'b0;
      launch_ready_q <= 1'b1;
      busy_q         <= 1'b0;
      out_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      tid_q          <= tid_d;
      lin_q          <= lin_d;
      ntid_q         <= ntid_d;
      ctaid_q        <= ctaid_d;
      nctaid_q       <= nctaid_d;
      sel_q          <= sel_d;
      const_q        <= const_d;
      out_valid_q    <= out_valid_d;
      out_last_q     <= out_last_d;
      launch_ready_q <= launch_ready_d;
      busy_q         <= busy_d;
      out_data_q     <= out_data_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign launch_ready = launch_ready_q;
  assign busy         = busy_q;
  assign out_data     = out_data_q;

endmodule

// File: tb/tb_dice_special_reg_seq.sv
// Self-checking bench for dice_special_reg_seq: table of CTA launches with a
// per-thread scoreboard, plus hand sequences for empty CTA, clr, cfg and rst.
module tb_dice_special_reg_seq;

  logic         clk = 1'b0;
  logic         rst, clr, cfg_we, launch_valid, launch_ready;
  logic [1:0]   cfg_idx;
  logic [31:0]  cfg_data;
  logic [9:0]   ntid_x, ntid_y, ntid_z;
  logic [15:0]  ctaid_x, ctaid_y, ctaid_z, nctaid_x, nctaid_y, nctaid_z;
  logic [19:0]  port_sel;
  logic         out_valid, out_ready, out_last, busy;
  logic [127:0] out_data;

  always #5 clk = ~clk;

  dice_special_reg_seq #(
    .DATA_WIDTH(32), .NUM_PORTS(4), .NUM_CONST(4), .MAX_NTID(512), .CTA_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .launch_valid(launch_valid), .launch_ready(launch_ready),
    .ntid_x(ntid_x), .ntid_y(ntid_y), .ntid_z(ntid_z),
    .ctaid_x(ctaid_x), .ctaid_y(ctaid_y), .ctaid_z(ctaid_z),
    .nctaid_x(nctaid_x), .nctaid_y(nctaid_y), .nctaid_z(nctaid_z),
    .port_sel(port_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_data(out_data), .busy(busy)
  );

  typedef struct {
    logic [9:0]  nx, ny, nz;
    logic [15:0] cx, cy, cz, ncx, ncy, ncz;
    logic [19:0] sels;
    bit          stall;
    int          beats;
  } vec_t;

  typedef struct {
    int          tx, ty, tz;
    logic [31:0] lin;
    bit          last;
  } exp_t;

  exp_t        q[$];
  vec_t        vecs[5];
  vec_t        cur;
  logic [31:0] cm [4];
  int          total = 0;
  int          bad = 0;
  int          beats = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mkvec(input int nx, input int ny, input int nz,
                                 input int cx, input int cy, input int cz,
                                 input int ncx, input int ncy, input int ncz,
                                 input logic [19:0] sels, input bit stall, input int nb);
    vec_t v;
    v.nx = 10'(nx); v.ny = 10'(ny); v.nz = 10'(nz);
    v.cx = 16'(cx); v.cy = 16'(cy); v.cz = 16'(cz);
    v.ncx = 16'(ncx); v.ncy = 16'(ncy); v.ncz = 16'(ncz);
    v.sels = sels; v.stall = stall; v.beats = nb;
    return v;
  endfunction

  // Reference output word for one thread, using the current descriptor and constants.
  function automatic logic [127:0] exp_data(input exp_t e);
    logic [127:0] d;
    logic [4:0]   s;
    logic [31:0]  v;
    d = '0;
    for (int p = 0; p < 4; p++) begin
      s = cur.sels[p*5 +: 5];
      case (s)
        5'd0:  v = 32'(e.tx);
        5'd1:  v = 32'(e.ty);
        5'd2:  v = 32'(e.tz);
        5'd3:  v = 32'(cur.nx);
        5'd4:  v = 32'(cur.ny);
        5'd5:  v = 32'(cur.nz);
        5'd6:  v = 32'(cur.cx);
        5'd7:  v = 32'(cur.cy);
        5'd8:  v = 32'(cur.cz);
        5'd9:  v = 32'(cur.ncx);
        5'd10: v = 32'(cur.ncy);
        5'd11: v = 32'(cur.ncz);
        5'd12: v = e.lin;
        5'd16, 5'd17, 5'd18, 5'd19: v = cm[int'(s) - 16];
        default: v = '0;
      endcase
      d[p*32 +: 32] = v;
    end
    return d;
  endfunction

  // One clock: compare the presented beat, then advance past the edge.
  task automatic cycle(input logic rdy);
    exp_t e;
    bit   was_last;
    was_last = 0;
    out_ready = rdy;
    if (out_valid) begin
      if (q.size() == 0) begin
        check("extra_beat", 1, 0);
      end else begin
        e = q[0];
        check("data", out_data, exp_data(e));
        check("last", 128'(out_last), 128'(e.last));
        if (rdy) begin
          void'(q.pop_front());
          beats++;
          was_last = e.last;
        end
      end
    end
    @(posedge clk); #1;
    if (cfg_we) begin
      cm[cfg_idx] = cfg_data;
      cfg_we = 1'b0;
    end
    if (was_last) begin
      check("ready_after_last", 128'(launch_ready), 1);
      check("valid_after_last", 128'(out_valid), 0);
    end
  endtask

  task automatic launch(input vec_t v);
    int  lin;
    bit  nz_ok;
    ntid_x = v.nx; ntid_y = v.ny; ntid_z = v.nz;
    ctaid_x = v.cx; ctaid_y = v.cy; ctaid_z = v.cz;
    nctaid_x = v.ncx; nctaid_y = v.ncy; nctaid_z = v.ncz;
    port_sel = v.sels;
    check("launch_ready", 128'(launch_ready), 1);
    cur = v;
    lin = 0;
    for (int z = 0; z < int'(v.nz); z++)
      for (int y = 0; y < int'(v.ny); y++)
        for (int x = 0; x < int'(v.nx); x++) begin
          q.push_back('{tx: x, ty: y, tz: z, lin: 32'(lin),
                        last: (x == int'(v.nx) - 1) && (y == int'(v.ny) - 1) &&
                              (z == int'(v.nz) - 1)});
          lin++;
        end
    nz_ok = (v.nx != 0) && (v.ny != 0) && (v.nz != 0);
    launch_valid = 1'b1;
    cycle(1'b0);
    launch_valid = 1'b0;
    check("first_valid", 128'(out_valid), 128'(nz_ok));
  endtask

  task automatic drain(input bit stall, input int exp_beats);
    int n;
    n = 0;
    beats = 0;
    while (q.size() != 0 && n < 200) begin
      cycle(stall ? 1'((n % 2) == 0) : 1'b1);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL drain_timeout remaining=%0d required=0", q.size());
    end
    check("beat_count", 128'(beats), 128'(exp_beats));
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; clr = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0;
    launch_valid = 1'b0; out_ready = 1'b0; port_sel = '0;
    ntid_x = '0; ntid_y = '0; ntid_z = '0;
    ctaid_x = '0; ctaid_y = '0; ctaid_z = '0;
    nctaid_x = '0; nctaid_y = '0; nctaid_z = '0;
    for (int i = 0; i < 4; i++) cm[i] = '0;

    vecs[0] = mkvec(2, 2, 1, 0, 0, 0, 0, 0, 0, {5'd16, 5'd12, 5'd1, 5'd0}, 1'b0, 4);
    vecs[1] = mkvec(3, 1, 2, 3, 4, 5, 6, 7, 8, {5'd2, 5'd5, 5'd12, 5'd0}, 1'b1, 6);
    vecs[2] = mkvec(2, 1, 1, 'hFFFF, 0, 0, 0, 0, 'h1234, {5'd31, 5'd13, 5'd11, 5'd6}, 1'b0, 2);
    vecs[3] = mkvec(1, 1, 1, 1, 2, 3, 7, 8, 9, {5'd10, 5'd9, 5'd4, 5'd3}, 1'b0, 1);
    vecs[4] = mkvec(2, 3, 2, 5, 6, 'h77, 1, 1, 1, {5'd1, 5'd2, 5'd8, 5'd7}, 1'b1, 12);

    @(posedge clk); #1;
    check("rst_valid", 128'(out_valid), 0);
    check("rst_last", 128'(out_last), 0);
    check("rst_busy", 128'(busy), 0);
    check("rst_ready", 128'(launch_ready), 1);
    check("rst_data", out_data, 0);
    rst = 1'b0;

    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_data = 32'hABCD;
    cycle(1'b0);

    for (int i = 0; i < 5; i++) begin
      launch(vecs[i]);
      drain(vecs[i].stall, vecs[i].beats);
    end

    // Empty CTA: no beats, launch_ready stays available.
    v = mkvec(2, 0, 1, 0, 0, 0, 0, 0, 0, {5'd0, 5'd0, 5'd0, 5'd0}, 1'b0, 0);
    launch(v);
    check("empty_busy", 128'(busy), 0);
    cycle(1'b1);
    check("empty_valid2", 128'(out_valid), 0);
    check("empty_ready2", 128'(launch_ready), 1);

    // clr on beat 2 aborts; relaunch restarts at thread 0 with constants intact.
    v = mkvec(4, 1, 1, 0, 0, 0, 0, 0, 0, {5'd3, 5'd16, 5'd12, 5'd0}, 1'b0, 4);
    launch(v);
    cycle(1'b1);
    clr = 1'b1;
    cycle(1'b1);
    clr = 1'b0;
    q.delete();
    check("clr_valid", 128'(out_valid), 0);
    check("clr_busy", 128'(busy), 0);
    check("clr_ready", 128'(launch_ready), 1);
    launch(v);
    drain(1'b0, 4);

    // Constant rewrite mid-run becomes visible one cycle after cfg_we.
    v = mkvec(4, 1, 1, 0, 0, 0, 0, 0, 0, {5'd16, 5'd12, 5'd0, 5'd17}, 1'b0, 4);
    launch(v);
    cycle(1'b1);
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_data = 32'h55;
    cycle(1'b1);
    check("cfg_visible", out_data[31:0], 32'h55);
    drain(1'b0, 2);

    // Reset mid-run clears everything, constants included.
    launch(v);
    cycle(1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 4; i++) cm[i] = '0;
    check("mid_rst_valid", 128'(out_valid), 0);
    check("mid_rst_last", 128'(out_last), 0);
    check("mid_rst_busy", 128'(busy), 0);
    check("mid_rst_ready", 128'(launch_ready), 1);
    check("mid_rst_data", out_data, 0);
    launch(v);
    check("const1_after_rst", out_data[31:0], 0);
    drain(1'b0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dice_special_reg_seq.md
DICE_SPECIAL_REG_SEQ -- requirements
Module: dice_special_reg_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, output word width.
REQ-002 SHALL have parameter NUM_PORTS, default 4, number of independent read ports.
REQ-003 SHALL have parameter NUM_CONST, default 4, number of constant registers; range 1..16.
REQ-004 SHALL have parameter MAX_NTID, default 512, max threads per dimension; TID_WIDTH=$clog2(MAX_NTID), DIM_WIDTH=TID_WIDTH+1.
REQ-005 SHALL have parameter CTA_WIDTH, default 16, width of ctaid/nctaid fields.
REQ-006 SHALL have: clk  in  1  sole clock, all state updates on rising edge.
REQ-007 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have: clr  in  1  synchronous soft abort.
REQ-009 SHALL have: cfg_we in 1; cfg_idx in $clog2(NUM_CONST); cfg_data in DATA_WIDTH: constant register write port.
REQ-010 SHALL have: launch_valid in 1; launch_ready out 1: CTA descriptor handshake.
REQ-011 SHALL have: ntid_x/y/z in DIM_WIDTH each; ctaid_x/y/z, nctaid_x/y/z in CTA_WIDTH each: CTA descriptor.
REQ-012 SHALL have: port_sel in NUM_PORTS x 5: per-port source select.
REQ-013 SHALL have: out_valid out 1; out_ready in 1; out_last out 1; out_data out NUM_PORTS x DATA_WIDTH: per-thread output stream.
REQ-014 SHALL have: busy out 1, high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE and RUN; launch_ready=1 only in IDLE; out_valid=1 only in RUN.
REQ-016 SHALL, in IDLE on launch_valid&launch_ready, latch descriptor and port_sel, clear tid_x/y/z and linear counter to 0, enter RUN next cycle.
REQ-017 SHALL, if any latched ntid dimension is 0, remain/return to IDLE after the launch cycle with no out_valid pulse.
REQ-018 SHALL present thread (0,0,0) with out_valid=1 in the cycle after the launch handshake (1-cycle latency).
REQ-019 SHALL advance only on out_valid&out_ready: tid_x++; at tid_x==ntid_x-1 wrap to 0 and tid_y++; at tid_y==ntid_y-1 wrap and tid_z++; linear counter +1 (no multiplier).
REQ-020 SHALL assert out_last when tid_x==ntid_x-1, tid_y==ntid_y-1, tid_z==ntid_z-1; handshake on out_last returns FSM to IDLE next cycle.
REQ-021 SHALL hold out_data, out_last stable while out_valid&!out_ready.
REQ-022 SHALL drive each out_data[p] from registered state via latched sel: 0-2 tid_x/y/z; 3-5 ntid_x/y/z; 6-8 ctaid_x/y/z; 9-11 nctaid_x/y/z; 12 linear tid; 16..16+NUM_CONST-1 const[sel-16]; all other codes 0.
REQ-023 SHALL zero-extend every field to DATA_WIDTH; linear counter is DATA_WIDTH wide and wraps modulo 2^DATA_WIDTH.
REQ-024 SHALL apply cfg writes in the cycle after cfg_we, in any state; a selected const port reflects the new value from that next cycle.
REQ-025 SHALL NOT accept a new launch in the same cycle as the final out_last handshake; launch_ready rises the following cycle.
REQ-026 SHALL, on clr, enter IDLE next cycle, drop out_valid, zero tid and linear counters, retain constants; clr overrides a simultaneous launch or output handshake.

Reset
REQ-027 SHALL, on rst, set state IDLE, all tid/linear counters, latched descriptor, latched port_sel and all constant registers to 0; out_valid=0, out_last=0, busy=0, launch_ready=1 in the first cycle after reset; out_data=0.
REQ-028 SHALL give rst priority over clr, cfg_we and all handshakes; rst mid-RUN aborts with no further out_valid.

Verification
REQ-029 ntid=(2,2,1), port sels {0,1,12,16}, const0=0xABCD, out_ready=1 -> 4 beats, tid_x 0,1,0,1; tid_y 0,0,1,1; linear 0..3; port3=0xABCD; out_last on beat 4 only; launch_ready back next cycle.
REQ-030 ntid=(3,1,2), out_ready toggled 1/0 -> 6 beats, no dup/skip, data stable during stall cycles, last beat tid=(2,0,1), linear=5.
REQ-031 ntid_y=0 launch -> no out_valid, busy for at most 1 cycle, launch_ready=1 two cycles after handshake.
REQ-032 clr asserted on beat 2 of ntid=(4,1,1) run with out_ready=1 -> out_valid=0 next cycle, next launch restarts at tid (0,0,0), constants unchanged.
REQ-033 cfg write const1=0x55 mid-run with port_sel=17 -> out_data shows old value until cycle after cfg_we, then 0x55; rst mid-run -> all outputs 0, const1 reads 0 after relaunch.
REQ-034 ctaid_x=0xFFFF, nctaid_z=0x1234, sels {6,11,13,31} -> out_data 0x0000FFFF, 0x00001234, 0, 0 on every beat.
